// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SUB_DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor D = A - B - Bin, LSB first, one full-subtractor cell.
// Optional signed-overflow output V is built when SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = SUB_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         Bout,
  output state_t       state_dbg
`ifdef SUB_OVF_EN
  ,
  output logic         V
`endif
);

  // Handshake: start is sampled only in IDLE; busy is high for the N SHIFT
  // cycles; done is a one-cycle pulse after the last bit, when D/Bout (and V)
  // have just been updated. start in SHIFT or DONE is ignored.

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nx;
  logic [N-1:0]  a_sr, b_sr, acc;
  logic          br;
  logic [CW-1:0] cnt;
  logic          cell_d, cell_bout;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
`ifdef SUB_OVF_EN
      V     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      busy  <= (state_nx == SHIFT);
      done  <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            br   <= Bin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr <= {1'b0, a_sr[N-1:1]};
          b_sr <= {1'b0, b_sr[N-1:1]};
          acc  <= {cell_d, acc[N-1:1]};
          br   <= cell_bout;
          cnt  <= cnt + CW'(1);
          // Results are published only on the last bit so D never shows partials.
          if (cnt == LAST) begin
            D    <= {cell_d, acc[N-1:1]};
            Bout <= cell_bout;
`ifdef SUB_OVF_EN
            // On the last step a_sr[0]/b_sr[0] are the captured sign bits.
            V    <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
